payment_ctrl: RTL
=================

PAYMENT_CTRL -- requirements
Module: payment_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 500_000_000, is the number of idle cycles without a coin before refund (5 s at 100 MHz).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 state  input  4  mode-controller state code (package encodings, e.g. S_PAYMENT=4'b0010, S_INQUIRE=4'b0001, S_OFF=4'b0000).
REQ-005 price  input  10  total amount due, sampled on payment entry.
REQ-006 coin_1 / coin_5 / coin_10  input  1 each  synchronous coin-slot levels worth 1, 5 and 10 units.
REQ-007 paid  output  10  accumulated money this transaction.
REQ-008 change  output  10  amount to return; valid in DONE/REFUND.
REQ-009 finish  output  1  one-cycle pulse ending the payment, consumed by the mode controller.
REQ-010 pay_ok  output  1  1 = paid in full, 0 = refunded; valid in DONE/REFUND.

Function
REQ-011 Internal FSM SHALL have states IDLE, COLLECT, DONE, REFUND.
REQ-012 IDLE: paid=0, change=0, pay_ok=0; when state==S_PAYMENT, latch price into price_q, clear timer, go to COLLECT.
REQ-013 Each coin input SHALL be rising-edge detected (level & ~previous level); a held level counts once.
REQ-014 In COLLECT, a detected edge adds its value to paid on the same clock edge. Simultaneous edges add the sum of all values.
REQ-015 paid SHALL saturate at 1023 and never wrap.
REQ-016 In COLLECT, when registered paid >= price_q: go to DONE on the next edge, pulse finish for exactly 1 cycle, set pay_ok=1, change=paid-price_q.
REQ-017 Latency: finish goes high two clock edges after the edge that detects the completing coin.
REQ-018 price_q==0 SHALL complete to DONE one cycle after entering COLLECT, with change=0.
REQ-019 Timer increments every COLLECT cycle and clears on any coin edge. On reaching TIMEOUT-1: go to REFUND, pulse finish, pay_ok=0, change=paid.
REQ-020 If state leaves S_PAYMENT while in COLLECT (return, admin, off): go to REFUND with change=paid, pay_ok=0, and no finish pulse. This takes priority over completion and timeout in the same cycle.
REQ-021 Coin edges in DONE/REFUND/IDLE SHALL be ignored.
REQ-022 DONE/REFUND hold paid, change and pay_ok until state is S_INQUIRE or S_OFF, then return to IDLE, clearing all outputs.
REQ-023 finish SHALL never be high for two consecutive cycles.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and clear paid, change, finish, pay_ok, timer, price_q and the edge registers, including mid-transaction.
REQ-025 After reset release, a coin level already high SHALL NOT count as an edge until it goes low and high again.

Structure
REQ-026 Shared package vm_pkg SHALL hold the 4-bit state codes shared with the mode controller and the coin value constants 1/5/10.
REQ-027 Sub-module coin_edge (one instance per coin) SHALL implement REQ-013; the FSM, accumulator and timer live in payment_ctrl.

Verification
REQ-028 The bench SHALL use TIMEOUT=20 and cover these scenarios:
- Exact pay: price=15, state=S_PAYMENT, pulse coin_10 then coin_5 -> paid=15, finish 1 cycle, pay_ok=1, change=0.
- Overpay with simultaneous coins: price=12, coin_10 and coin_5 in the same cycle -> paid=15, change=3, pay_ok=1.
- Timeout: price=20, one coin_5, then 20 idle cycles -> finish pulse, pay_ok=0, change=5.
- Abort: price=30, coin_10, then state->S_INQUIRE -> REFUND with change=10, no finish pulse, then IDLE with paid=0.
- Held level and saturation: coin_1 held for 10 cycles -> paid=1. Price=1023 with repeated coin_10 -> paid stops at 1023 and completes.
- Reset mid-COLLECT with paid=7 -> all outputs 0 immediately; a held coin is not counted after release.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: state codes shared with the mode controller, coin values and the payment FSM states.
package vm_pkg;
   localparam logic [3:0] S_OFF     = 4'b0000;
   localparam logic [3:0] S_INQUIRE = 4'b0001;
   localparam logic [3:0] S_PAYMENT = 4'b0010;
   localparam logic [9:0] COIN_1    = 10'd1;
   localparam logic [9:0] COIN_5    = 10'd5;
   localparam logic [9:0] COIN_10   = 10'd10;
   localparam logic [9:0] PAID_MAX  = 10'd1023;
   typedef enum logic [1:0] {IDLE, COLLECT, DONE, REFUND} pay_st_e;
endpackage

// File: rtl/payment_ctrl_if.sv
// payment_ctrl_if: mode-controller <-> payment controller signal bundle.
interface payment_ctrl_if;
   logic [3:0] state;
   logic [9:0] price;
   logic       coin_1;
   logic       coin_5;
   logic       coin_10;
   logic [9:0] paid;
   logic [9:0] change;
   logic       finish;
   logic       pay_ok;
   modport master (output state, price, coin_1, coin_5, coin_10, input paid, change, finish, pay_ok);
   modport slave  (input state, price, coin_1, coin_5, coin_10, output paid, change, finish, pay_ok);
endinterface

// File: rtl/payment_ctrl_coin_edge.sv
// coin_edge: rising-edge detector for one coin slot level; a held level yields a single pulse.
module coin_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic lvl_i,
   output logic edge_o
);
   logic prev_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= lvl_i;
   assign edge_o = lvl_i & ~prev_q;
endmodule

// File: rtl/payment_ctrl.sv
// payment_ctrl: coin accumulation, completion/timeout/abort FSM and one-cycle finish pulse.
module payment_ctrl
   import vm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 500_000_000
) (
   input logic           clk,
   input logic           rst_n,
   payment_ctrl_if.slave bus
);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   pay_st_e        st_q, st_d;
   logic [9:0]     paid_q, paid_d, change_q, change_d, price_q, price_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           ok_q, ok_d, note_q, note_d, fin_q, fin_d;
   logic           e1, e5, e10, any_edge;
   logic [10:0]    sum;
   coin_edge u_c1  (.clk(clk), .rst_n(rst_n), .lvl_i(bus.coin_1),  .edge_o(e1));
   coin_edge u_c5  (.clk(clk), .rst_n(rst_n), .lvl_i(bus.coin_5),  .edge_o(e5));
   coin_edge u_c10 (.clk(clk), .rst_n(rst_n), .lvl_i(bus.coin_10), .edge_o(e10));
   assign any_edge = e1 | e5 | e10;
   assign sum = {1'b0, paid_q} + (e1 ? 11'(COIN_1) : 11'd0) + (e5 ? 11'(COIN_5) : 11'd0)
              + (e10 ? 11'(COIN_10) : 11'd0);
   // finish lags the DONE/REFUND transition by one edge; note_q marks the non-abort exits
   always_comb begin
      st_d     = st_q;
      paid_d   = paid_q;
      change_d = change_q;
      price_d  = price_q;
      timer_d  = timer_q;
      ok_d     = ok_q;
      note_d   = 1'b0;
      fin_d    = note_q && (st_q == DONE || st_q == REFUND);
      case (st_q)
         IDLE: if (bus.state == S_PAYMENT) begin
            st_d    = COLLECT;
            price_d = bus.price;
            timer_d = '0;
         end
         COLLECT: if (bus.state != S_PAYMENT) begin
            st_d     = REFUND;
            change_d = paid_q;
         end else if (paid_q >= price_q) begin
            st_d     = DONE;
            ok_d     = 1'b1;
            change_d = paid_q - price_q;
            note_d   = 1'b1;
         end else if (timer_q == TW'(TIMEOUT - 1) && !any_edge) begin
            st_d     = REFUND;
            change_d = paid_q;
            note_d   = 1'b1;
         end else begin
            paid_d  = (sum > 11'(PAID_MAX)) ? PAID_MAX : sum[9:0];
            timer_d = any_edge ? '0 : timer_q + TW'(1);
         end
         default: if (bus.state == S_INQUIRE || bus.state == S_OFF) begin
            st_d     = IDLE;
            paid_d   = '0;
            change_d = '0;
            ok_d     = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st_q     <= IDLE;
         paid_q   <= '0;
         change_q <= '0;
         price_q  <= '0;
         timer_q  <= '0;
         ok_q     <= 1'b0;
         note_q   <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         st_q     <= st_d;
         paid_q   <= paid_d;
         change_q <= change_d;
         price_q  <= price_d;
         timer_q  <= timer_d;
         ok_q     <= ok_d;
         note_q   <= note_d;
         fin_q    <= fin_d;
      end
   assign bus.paid   = paid_q;
   assign bus.change = change_q;
   assign bus.pay_ok = ok_q;
   assign bus.finish = fin_q;
endmodule
